// File: rtl/capture_pkg.sv
// capture_pkg: shared constants for the capture sequencer.
//   - Command opcodes carried on i_cmd_op.
//   - State encodings reported on o_state.
//   - Default sampling prescaler.
package capture_pkg;

    localparam logic [7:0] OP_SET_START = 8'h01;
    localparam logic [7:0] OP_SET_END   = 8'h02;
    localparam logic [7:0] OP_SET_LIMIT = 8'h03;
    localparam logic [7:0] OP_SET_PRESC = 8'h04;
    localparam logic [7:0] OP_ARM       = 8'h10;
    localparam logic [7:0] OP_ABORT     = 8'h11;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_CLEAR      = 3'd1;
    localparam logic [2:0] ST_ARMED      = 3'd2;
    localparam logic [2:0] ST_CAPTURE    = 3'd3;
    localparam logic [2:0] ST_DRAIN_REQ  = 3'd4;
    localparam logic [2:0] ST_DRAIN_WAIT = 3'd5;
    localparam logic [2:0] ST_DRAIN_HOLD = 3'd6;

    localparam logic [31:0] PRESC_DEFAULT = 32'd1;

endpackage

// File: rtl/capture_sequencer_fifo_drain.sv
// fifo_drain: moves words from the capture FIFO to the host valid/ready port.
//   i_state              current sequencer state (acts only in DRAIN_* states)
//   i_abort              accepted ABORT this cycle; drops any pending host word
//   i_load/i_load_word   push a word straight into the host holding register
//   i_fifo_empty/i_fifo_q FIFO status and read data (data one cycle after read)
//   i_data_ready         host accept
//   o_fifo_read          FIFO read strike, only when FIFO is non-empty
//   o_data/o_data_valid  host word and valid, held stable until accepted
//   o_next_state         drain-phase next state (IDLE once the FIFO is empty)
//   o_finish             FIFO found empty in DRAIN_REQ: capture complete
module fifo_drain
    import capture_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              _mrst,
    input  logic [2:0]        i_state,
    input  logic              i_abort,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_word,
    input  logic              i_fifo_empty,
    input  logic [DATA_W-1:0] i_fifo_q,
    input  logic              i_data_ready,
    output logic              o_fifo_read,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    output logic [2:0]        o_next_state,
    output logic              o_finish
);

    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    always_comb begin
        data_d       = data_q;
        valid_d      = valid_q;
        o_next_state = ST_IDLE;
        o_finish     = 1'b0;
        o_fifo_read  = (i_state == ST_DRAIN_REQ) && !i_fifo_empty && !i_abort;
        case (i_state)
            ST_DRAIN_REQ: begin
                if (i_fifo_empty) o_finish = 1'b1;
                else              o_next_state = ST_DRAIN_WAIT;
            end
            ST_DRAIN_WAIT: begin
                data_d       = i_fifo_q;
                valid_d      = 1'b1;
                o_next_state = ST_DRAIN_HOLD;
            end
            ST_DRAIN_HOLD: begin
                if (i_data_ready) begin
                    valid_d      = 1'b0;
                    o_next_state = ST_DRAIN_REQ;
                end else begin
                    o_next_state = ST_DRAIN_HOLD;
                end
            end
            default: ;
        endcase
        if (i_load) begin
            data_d  = i_load_word;
            valid_d = 1'b1;
        end
        // Abort wins over everything: the held word is discarded.
        if (i_abort) valid_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge _mrst) begin
        if (!_mrst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = valid_q;

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: host-side controller for one logic-analyzer channel and
// its capture FIFO. Holds trigger / limit / prescaler config written via a
// 32-bit command port, sequences clear -> arm -> capture -> drain, and streams
// FIFO words to the host over valid/ready.
//   Command:  i_cmd_valid/i_cmd_op/i_cmd_arg in, o_cmd_ready out
//   Config:   o_start_trig_*, o_end_trig_*, o_sample_limit, o_do_sample_limit,
//             o_time_prescaler
//   Channel:  o_chan_rst_n, o_fifo_clear, i_run
//   FIFO:     i_fifo_empty, o_fifo_read, i_fifo_q
//   Host:     o_data, o_data_valid, i_data_ready
//   Status:   o_state, o_done (1-cycle pulse), o_err (sticky, cleared by ARM)
// Optional: define CAPTURE_TIMESTAMP_EN to emit the ARMED->CAPTURE latency
// (in cycles) as the first host word of every capture.
module capture_sequencer
    import capture_pkg::*;
#(
    parameter int CLR_CYCLES  = 4,
    parameter int ARM_TIMEOUT = 0,
    parameter int DATA_W      = 32
) (
    input  logic              i_clk,
    input  logic              _mrst,
    input  logic              i_cmd_valid,
    input  logic [7:0]        i_cmd_op,
    input  logic [31:0]       i_cmd_arg,
    output logic              o_cmd_ready,
    output logic [2:0]        o_start_trig_idx,
    output logic              o_start_trig_edge,
    output logic              o_start_trig_en_n,
    output logic [2:0]        o_end_trig_idx,
    output logic              o_end_trig_edge,
    output logic              o_end_trig_en_n,
    output logic [31:0]       o_sample_limit,
    output logic              o_do_sample_limit,
    output logic [31:0]       o_time_prescaler,
    output logic              o_chan_rst_n,
    output logic              o_fifo_clear,
    input  logic              i_run,
    input  logic              i_fifo_empty,
    output logic              o_fifo_read,
    input  logic [DATA_W-1:0] i_fifo_q,
    output logic [DATA_W-1:0] o_data,
    output logic              o_data_valid,
    input  logic              i_data_ready,
    output logic [2:0]        o_state,
    output logic              o_done,
    output logic              o_err
);

    localparam int              CLR_W    = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);
    localparam logic [31:0]     TMO_LAST = 32'(ARM_TIMEOUT) - 32'd1;

    logic [2:0]       state_q, state_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             clr_to_idle_q, clr_to_idle_d;   // CLEAR exits to IDLE, not ARMED
    logic [31:0]      tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             chan_rst_n_q, chan_rst_n_d;
    logic             fifo_clear_q, fifo_clear_d;
    logic [2:0]       start_idx_q, start_idx_d, end_idx_q, end_idx_d;
    logic             start_edge_q, start_edge_d, end_edge_q, end_edge_d;
    logic             start_en_n_q, start_en_n_d, end_en_n_q, end_en_n_d;
    logic [31:0]      limit_q, limit_d, presc_q, presc_d;
    logic             do_limit_q, do_limit_d;

    logic              cmd_acc, abort_acc;
    logic [2:0]        drain_next, capture_next;
    logic              drain_finish, ts_load;
    logic [DATA_W-1:0] ts_word;

    assign o_cmd_ready = (state_q == ST_IDLE) || (i_cmd_op == OP_ABORT);
    assign cmd_acc     = i_cmd_valid && o_cmd_ready;
    assign abort_acc   = cmd_acc && (i_cmd_op == OP_ABORT);

`ifdef CAPTURE_TIMESTAMP_EN
    // Counts ARMED cycles; stops counting once i_run is seen, so it holds the
    // arm-to-run latency through the drain.
    logic [31:0] ts_q, ts_d;
    always_comb begin
        ts_d = ts_q;
        if (state_q == ST_CLEAR && state_d == ST_ARMED)
            ts_d = '0;
        else if (state_q == ST_ARMED && !i_run && ts_q != '1)
            ts_d = ts_q + 32'd1;
    end
    always_ff @(posedge i_clk or negedge _mrst) begin
        if (!_mrst) ts_q <= '0;
        else        ts_q <= ts_d;
    end
    assign ts_load      = (state_q == ST_CAPTURE) && !i_run;
    assign ts_word      = DATA_W'(ts_q);
    assign capture_next = ST_DRAIN_HOLD;   // timestamp goes out before the FIFO words
`else
    assign ts_load      = 1'b0;
    assign ts_word      = '0;
    assign capture_next = ST_DRAIN_REQ;
`endif

    fifo_drain #(.DATA_W(DATA_W)) u_drain (
        .i_clk        (i_clk),
        ._mrst        (_mrst),
        .i_state      (state_q),
        .i_abort      (abort_acc),
        .i_load       (ts_load),
        .i_load_word  (ts_word),
        .i_fifo_empty (i_fifo_empty),
        .i_fifo_q     (i_fifo_q),
        .i_data_ready (i_data_ready),
        .o_fifo_read  (o_fifo_read),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_next_state (drain_next),
        .o_finish     (drain_finish)
    );

    always_comb begin
        state_d       = state_q;
        clr_cnt_d     = clr_cnt_q;
        clr_to_idle_d = clr_to_idle_q;
        tmo_d         = tmo_q;
        err_d         = err_q;
        done_d        = 1'b0;
        start_idx_d   = start_idx_q;
        start_edge_d  = start_edge_q;
        start_en_n_d  = start_en_n_q;
        end_idx_d     = end_idx_q;
        end_edge_d    = end_edge_q;
        end_en_n_d    = end_en_n_q;
        limit_d       = limit_q;
        do_limit_d    = do_limit_q;
        presc_d       = presc_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_acc) begin
                    case (i_cmd_op)
                        OP_SET_START: begin
                            start_idx_d  = i_cmd_arg[2:0];
                            start_edge_d = i_cmd_arg[3];
                            start_en_n_d = ~i_cmd_arg[4];
                        end
                        OP_SET_END: begin
                            end_idx_d  = i_cmd_arg[2:0];
                            end_edge_d = i_cmd_arg[3];
                            end_en_n_d = ~i_cmd_arg[4];
                        end
                        OP_SET_LIMIT: begin
                            limit_d    = i_cmd_arg;
                            do_limit_d = (i_cmd_arg != '0);
                        end
                        OP_SET_PRESC: presc_d = (i_cmd_arg == '0) ? PRESC_DEFAULT : i_cmd_arg;
                        OP_ARM: begin
                            state_d       = ST_CLEAR;
                            clr_cnt_d     = '0;
                            clr_to_idle_d = 1'b0;
                            err_d         = 1'b0;
                        end
                        OP_ABORT: ;
                        default:  err_d = 1'b1;
                    endcase
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = clr_to_idle_q ? ST_IDLE : ST_ARMED;
                    tmo_d   = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            ST_ARMED: begin
                // i_run has priority over a timeout expiring in the same cycle.
                if (i_run) begin
                    state_d = ST_CAPTURE;
                end else if (ARM_TIMEOUT != 0 && tmo_q >= TMO_LAST) begin
                    err_d         = 1'b1;
                    state_d       = ST_CLEAR;
                    clr_cnt_d     = '0;
                    clr_to_idle_d = 1'b1;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            ST_CAPTURE: if (!i_run) state_d = capture_next;
            default: begin
                state_d = drain_next;
                done_d  = drain_finish;
            end
        endcase
        if (abort_acc) begin
            state_d       = ST_CLEAR;
            clr_cnt_d     = '0;
            clr_to_idle_d = 1'b1;
            done_d        = 1'b0;
        end
    end

    // Channel/FIFO controls are registered from the next state so they line
    // up exactly with the cycles spent in each state.
    assign fifo_clear_d = (state_d == ST_CLEAR);
    assign chan_rst_n_d = (state_d >= ST_ARMED);

    always_ff @(posedge i_clk or negedge _mrst) begin
        if (!_mrst) begin
            state_q       <= ST_IDLE;
            clr_cnt_q     <= '0;
            clr_to_idle_q <= 1'b0;
            tmo_q         <= '0;
            err_q         <= 1'b0;
            done_q        <= 1'b0;
            chan_rst_n_q  <= 1'b0;
            fifo_clear_q  <= 1'b1;
            start_idx_q   <= '0;
            start_edge_q  <= 1'b0;
            start_en_n_q  <= 1'b1;
            end_idx_q     <= '0;
            end_edge_q    <= 1'b0;
            end_en_n_q    <= 1'b1;
            limit_q       <= '0;
            do_limit_q    <= 1'b0;
            presc_q       <= PRESC_DEFAULT;
        end else begin
            state_q       <= state_d;
            clr_cnt_q     <= clr_cnt_d;
            clr_to_idle_q <= clr_to_idle_d;
            tmo_q         <= tmo_d;
            err_q         <= err_d;
            done_q        <= done_d;
            chan_rst_n_q  <= chan_rst_n_d;
            fifo_clear_q  <= fifo_clear_d;
            start_idx_q   <= start_idx_d;
            start_edge_q  <= start_edge_d;
            start_en_n_q  <= start_en_n_d;
            end_idx_q     <= end_idx_d;
            end_edge_q    <= end_edge_d;
            end_en_n_q    <= end_en_n_d;
            limit_q       <= limit_d;
            do_limit_q    <= do_limit_d;
            presc_q       <= presc_d;
        end
    end

    assign o_start_trig_idx  = start_idx_q;
    assign o_start_trig_edge = start_edge_q;
    assign o_start_trig_en_n = start_en_n_q;
    assign o_end_trig_idx    = end_idx_q;
    assign o_end_trig_edge   = end_edge_q;
    assign o_end_trig_en_n   = end_en_n_q;
    assign o_sample_limit    = limit_q;
    assign o_do_sample_limit = do_limit_q;
    assign o_time_prescaler  = presc_q;
    assign o_chan_rst_n      = chan_rst_n_q;
    assign o_fifo_clear      = fifo_clear_q;
    assign o_state           = state_q;
    assign o_done            = done_q;
    assign o_err             = err_q;

endmodule
